// File: rtl/adc_arbiter_if.sv
// adc_arbiter_if: conversion-engine bus between the arbiter and the AD7265.
// master = arbiter side, slave = engine side.
interface adc_arbiter_if;
    logic        adc_req;
    logic [2:0]  adc_addr;
    logic        adc_rdy;
    logic [11:0] adc_data_a;
    logic [11:0] adc_data_b;

    modport master (
        output adc_req,
        output adc_addr,
        input  adc_rdy,
        input  adc_data_a,
        input  adc_data_b
    );

    modport slave (
        input  adc_req,
        input  adc_addr,
        output adc_rdy,
        output adc_data_a,
        output adc_data_b
    );
endinterface

// File: rtl/adc_arbiter.sv
// adc_arbiter: round-robin scheduler sharing one AD7265 engine.
// Define ADC_ARB_TIMEOUT_EN to enable the adc_rdy watchdog.
module adc_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] sel,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               err,
    output logic [11:0]        data,
    output logic               busy,
    adc_arbiter_if.master      adc
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_cur;
    logic [3:0]       r_cur_sel;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_done;
    logic             r_err;
    logic [11:0]      r_data;
    logic             r_busy;
    logic [2:0]       r_addr;

    logic             w_found;
    logic [PW-1:0]    w_win;
    logic [PW-1:0]    w_idx;
    logic [3:0]       w_sel;
    logic             w_bad;

`ifdef ADC_ARB_TIMEOUT_EN
    localparam logic [7:0] TO = 8'(TIMEOUT);
    logic [7:0] r_cnt;
`else
    logic w_unused_to;
    assign w_unused_to = (TIMEOUT != 0);
`endif

    // first pending requester at or after the pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_sel = sel[{w_win, 2'b00} +: 4];

    // mux addresses 0 and 7 never produce a conversion
    assign w_bad = (r_cur_sel[2:0] == 3'd0)
                || (r_cur_sel[2:0] == 3'd7);

    assign adc.adc_req  = (r_state == S_ISSUE)
                       && !w_bad && adc.adc_rdy;
    assign adc.adc_addr = r_addr;

    assign gnt  = r_gnt;
    assign done = r_done;
    assign err  = r_err;
    assign data = r_data;
    assign busy = r_busy;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_cur     <= '0;
            r_cur_sel <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_addr    <= '0;
`ifdef ADC_ARB_TIMEOUT_EN
            r_cnt     <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_cur     <= w_win;
                        r_cur_sel <= w_sel;
                        r_addr    <= w_sel[2:0];
                        r_gnt     <= N_REQ'(1) << w_win;
                        r_busy    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_bad) begin
                        r_err   <= 1'b1;
                        r_data  <= '0;
                        r_done  <= r_gnt;
                        r_state <= S_DONE;
                    end else if (adc.adc_rdy) begin
`ifdef ADC_ARB_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                        r_state <= S_GUARD;
                    end
                end
                S_GUARD: begin
`ifdef ADC_ARB_TIMEOUT_EN
                    r_cnt   <= r_cnt + 8'd1;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (adc.adc_rdy) begin
                        r_data  <= r_cur_sel[3]
                                 ? adc.adc_data_b
                                 : adc.adc_data_a;
                        r_err   <= 1'b0;
                        r_done  <= r_gnt;
                        r_state <= S_DONE;
                    end
`ifdef ADC_ARB_TIMEOUT_EN
                    else if (r_cnt == TO) begin
                        r_data  <= '0;
                        r_err   <= 1'b1;
                        r_done  <= r_gnt;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                    end
`endif
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= (r_cur == PW'(N_REQ - 1))
                             ? '0 : r_cur + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/adc_arbiter.md
# adc_arbiter

Round-robin scheduler that shares the single AD7265 conversion engine (req/addr/rdy/data_a/data_b interface) between several requesters, e.g. the per-row current-calibration sampler and a housekeeping monitor. It sits between those clients and the `ad7265` instance. It serialises conversions, selects the A or B result per request, rejects unconvertible mux addresses, and returns one 12-bit result per granted request.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- TIMEOUT, default 255: maximum cycles to wait for `adc_rdy` after issuing a conversion. Used only with the timeout watchdog enabled.

Ports:
- clock  in  1  system clock; every register is clocked on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req  in  N_REQ  per-requester conversion request, level; held until the matching `done`.
- sel  in  4*N_REQ  per-requester channel select, slice i = sel[4i+3:4i]; bit 3 selects B (1) or A (0), bits [2:0] are the AD7265 mux address. Must be stable while `req` is high.
- gnt  out  N_REQ  one-hot grant, registered.
- done  out  N_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  valid with `done`; 1 means invalid address or timeout.
- data  out  12  result, valid with `done`; held until the next `done`.
- busy  out  1  high whenever state is not IDLE.
- adc_req  out  1  conversion strobe to the AD7265 engine.
- adc_addr  out  3  mux address to the engine; held constant from ISSUE through WAIT.
- adc_rdy  in  1  engine idle / result valid.
- adc_data_a, adc_data_b  in  12 each  engine results.

## Operation
- States: IDLE, ISSUE, GUARD, WAIT, DONE.
- **IDLE**
  - If any `req` bit is set, pick the first set bit at or after the priority pointer `ptr`, scanning upward and wrapping.
  - Latch the winner's `sel` into `cur_sel`, set `gnt` one-hot, and go to ISSUE.
- **ISSUE**
  - If `cur_sel[2:0]` is 0 or 7, the engine would not convert. Go to DONE with err=1 and data=0, and do not assert `adc_req`.
  - Otherwise, assert `adc_req` for exactly one cycle, in the first cycle where `adc_rdy`=1, then go to GUARD. While `adc_rdy`=0, stay in ISSUE.
- **GUARD**: one cycle with `adc_rdy` ignored; this covers the engine's one-cycle rdy drop latency. Then go to WAIT.
- **WAIT**: when `adc_rdy`=1, capture `adc_data_b` if `cur_sel[3]`=1, else `adc_data_a`, into `data` with err=0, then go to DONE.
- **DONE**
  - Pulse `done[i]` for one cycle, set `ptr` = (i+1) mod N_REQ, clear `gnt`, and go to IDLE.
- `gnt` is high from ISSUE through DONE inclusive.
- If `req[i]` drops mid-operation, the conversion still completes and `done[i]` still pulses; it is not an abort.
- A requester that keeps `req` high after `done` is re-arbitrated normally. Because of the pointer rotation, any other pending requester wins first.
- Reset values: state=IDLE, ptr=0, gnt=0, done=0, err=0, data=0, busy=0, adc_req=0, adc_addr=0, cur_sel=0.
- A reset during any state returns to IDLE the next cycle with no `done` pulse. The engine shares the same reset.

## Timing
- Request arrival at edge k (sampled in IDLE):
  - `gnt` and `busy` high at k+1.
  - `adc_req` at k+1 if `adc_rdy`=1.
  - GUARD at k+2, WAIT from k+3.
- If `adc_rdy` returns at edge m ≥ k+3: `data`, `err` and `done` are valid during cycle m+1, and the arbiter is back in IDLE at m+2.
- Invalid address: `done` is valid at k+2.
- Minimum spacing between two grants is 1 idle cycle.
- `adc_req` never asserts outside ISSUE and never for two consecutive cycles.

## Configuration
- ADC_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to GUARD and increments in GUARD and WAIT.
  - When it reaches TIMEOUT without `adc_rdy`, go to DONE with err=1 and data=0.
- ADC_ARB_TIMEOUT_EN undefined: no counter; WAIT lasts indefinitely until `adc_rdy`.

## Test plan
- N_REQ=4, only req[2] high with sel[11:8]=4'hB, engine returns `adc_data_b`=12'h5A3 after 20 cycles -> exactly one `adc_req` pulse with adc_addr=3; done[2] pulses with data=12'h5A3 and err=0; gnt=4'b0100 from ISSUE through DONE.
- req=4'b1111 held continuously after reset -> grants follow the order 0,1,2,3,0; each `done` is followed by one idle cycle.
- req[1] with sel=4'h7, then 4'h0 -> done[1] 2 cycles after the request, err=1, data=0, `adc_req` never asserted.
- `adc_rdy` held 0 at request time for 5 cycles -> arbiter stays in ISSUE with `gnt` high; `adc_req` pulses in the cycle `adc_rdy` rises.
- reset_n low for one cycle during WAIT -> every output is 0 at the next edge; no `done` pulse; the next request is served from ptr=0.
- With ADC_ARB_TIMEOUT_EN and TIMEOUT=16, `adc_rdy` stuck 0 after `adc_req` -> `done` with err=1 and data=0 at the 16th WAIT/GUARD count; without the macro, `busy` stays high indefinitely.
